// File: rtl/anim_pkg.sv
// Shared types and defaults for the sprite animation counters.
package anim_pkg;

    typedef enum logic {
        ANIM_BOUNCE = 1'b0,
        ANIM_WRAP   = 1'b1
    } anim_mode_t;

    localparam int MOUTH_MAX_FRAME = 2;
    localparam int GHOST_MAX_FRAME = 1;

endpackage

// File: rtl/anim_prescaler.sv
// Divides qualifying frame ticks by PRESCALE; step pulses combinationally on
// the terminal qualifying tick so the owner can advance on that same edge.
module anim_prescaler #(
    parameter int PRESCALE = 1,
    parameter int PW       = $clog2(PRESCALE + 1)
) (
    input  logic clock,
    input  logic Reset,
    input  logic clear,
    input  logic en_tick,
    output logic step
);

    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic [PW-1:0] count;

    assign step = en_tick && !clear && (count == LAST);

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en_tick) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + ONE;
            end
        end
    end

endmodule

// File: rtl/sprite_anim_counter.sv
// Frame sequencer for one animated sprite: bounce or wrap through
// 0..MAX_FRAME, advancing once per PRESCALE qualifying ticks.
module sprite_anim_counter
    import anim_pkg::*;
#(
    parameter int MAX_FRAME = MOUTH_MAX_FRAME,
    parameter int PRESCALE  = 1,
    parameter int FW        = $clog2(MAX_FRAME + 1),
    parameter int PW        = $clog2(PRESCALE + 1)
) (
    input  logic          clock,
    input  logic          Reset,
    input  logic          tick,
    input  logic          enable,
    input  anim_mode_t    mode,
    input  logic          restart,
    output logic [FW-1:0] frame,
    output logic          dir_up,
    output logic          cycle_done
);

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    localparam logic [FW-1:0] MAXF = FW'(MAX_FRAME);
    localparam logic [FW-1:0] ONE  = FW'(1);

    logic          step;
    logic          going_up;
    logic [FW-1:0] nxt_frame;
    logic          nxt_dir;
    logic          nxt_done;

    anim_prescaler #(
        .PRESCALE (PRESCALE),
        .PW       (PW)
    ) u_prescaler (
        .clock   (clock),
        .Reset   (Reset),
        .clear   (restart),
        .en_tick (enable && tick),
        .step    (step)
    );

    // Leaving WRAP at the top frame with dir_up=1 must turn around rather than
    // climb past MAX_FRAME, so "up" also requires room above the current frame.
    assign going_up = ((dir_up == DIR_UP) || (frame == '0)) && (frame != MAXF);

    always_comb begin
        nxt_frame = frame;
        nxt_dir   = dir_up;
        nxt_done  = 1'b0;
        if (mode == ANIM_WRAP) begin
            nxt_dir = DIR_UP;
            if (frame == MAXF) begin
                nxt_frame = '0;
                nxt_done  = 1'b1;
            end else begin
                nxt_frame = frame + ONE;
            end
        end else if (going_up) begin
            nxt_frame = frame + ONE;
            nxt_dir   = (nxt_frame == MAXF) ? DIR_DOWN : DIR_UP;
        end else begin
            nxt_frame = frame - ONE;
            if (frame == ONE) begin
                nxt_dir  = DIR_UP;
                nxt_done = 1'b1;
            end else begin
                nxt_dir  = DIR_DOWN;
            end
        end
    end

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            frame      <= '0;
            dir_up     <= DIR_UP;
            cycle_done <= 1'b0;
        end else if (restart) begin
            frame      <= '0;
            dir_up     <= DIR_UP;
            cycle_done <= 1'b0;
        end else if (step) begin
            frame      <= nxt_frame;
            dir_up     <= nxt_dir;
            cycle_done <= nxt_done;
        end else begin
            cycle_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sprite_anim_counter.sv
// Self-checking bench: three counter configurations share one stimulus stream
// and are compared every cycle against a cycle-position reference model.
module tb_sprite_anim_counter;
    import anim_pkg::*;

    logic       clock;
    logic       Reset;
    logic       tick;
    logic       enable;
    anim_mode_t mode;
    logic       restart;

    logic [1:0] fa;
    logic       da, ca;
    logic [1:0] fb;
    logic       db, cb;
    logic [0:0] fc;
    logic       dc, cc;

    int passCount  = 0;
    int totalCount = 0;

    int maxf[3] = '{2, 3, 1};
    int pre[3]  = '{1, 4, 1};
    int mf[3];
    int md[3];
    int mp[3];
    int mc[3];

    typedef struct {
        logic t;
        logic e;
        logic w;
        logic r;
        int   f;
        int   d;
        int   c;
    } vec_t;

    vec_t tbl[12];

    sprite_anim_counter #(.MAX_FRAME(2), .PRESCALE(1)) u_a (
        .clock(clock), .Reset(Reset), .tick(tick), .enable(enable),
        .mode(mode), .restart(restart), .frame(fa), .dir_up(da), .cycle_done(ca)
    );

    sprite_anim_counter #(.MAX_FRAME(3), .PRESCALE(4)) u_b (
        .clock(clock), .Reset(Reset), .tick(tick), .enable(enable),
        .mode(mode), .restart(restart), .frame(fb), .dir_up(db), .cycle_done(cb)
    );

    sprite_anim_counter #(.MAX_FRAME(1), .PRESCALE(1)) u_c (
        .clock(clock), .Reset(Reset), .tick(tick), .enable(enable),
        .mode(mode), .restart(restart), .frame(fc), .dir_up(dc), .cycle_done(cc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        totalCount++;
        if (act == exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            mf[i] = 0;
            md[i] = 1;
            mp[i] = 0;
            mc[i] = 0;
        end
    endtask

    // Bounce is modelled as a position around a ring of 2*MAX steps
    // (positions 0..MAX-1 rising, MAX..2*MAX-1 falling); wrap as modulo MAX+1.
    task automatic modelAdvance(input int i);
        int pos;
        int m;
        m = maxf[i];
        if (mode == ANIM_WRAP) begin
            mf[i] = (mf[i] + 1) % (m + 1);
            mc[i] = (mf[i] == 0) ? 1 : 0;
            md[i] = 1;
        end else begin
            pos   = (md[i] == 1) ? mf[i] : 2 * m - mf[i];
            pos   = (pos + 1) % (2 * m);
            mf[i] = (pos <= m) ? pos : 2 * m - pos;
            md[i] = (pos < m) ? 1 : 0;
            mc[i] = (pos == 0) ? 1 : 0;
        end
    endtask

    task automatic modelStep();
        for (int i = 0; i < 3; i++) begin
            if (restart) begin
                mf[i] = 0;
                md[i] = 1;
                mp[i] = 0;
                mc[i] = 0;
            end else begin
                mc[i] = 0;
                if (enable && tick) begin
                    mp[i] = mp[i] + 1;
                    if (mp[i] == pre[i]) begin
                        mp[i] = 0;
                        modelAdvance(i);
                    end
                end
            end
        end
    endtask

    task automatic checkOutput();
        check("a_frame", int'(fa), mf[0]);
        check("a_dir",   int'(da), md[0]);
        check("a_done",  int'(ca), mc[0]);
        check("b_frame", int'(fb), mf[1]);
        check("b_dir",   int'(db), md[1]);
        check("b_done",  int'(cb), mc[1]);
        check("c_frame", int'(fc), mf[2]);
        check("c_dir",   int'(dc), md[2]);
        check("c_done",  int'(cc), mc[2]);
    endtask

    task automatic applyStimulus(input logic t, input logic e, input logic w, input logic r);
        tick    = t;
        enable  = e;
        mode    = w ? ANIM_WRAP : ANIM_BOUNCE;
        restart = r;
        @(posedge clock);
        modelStep();
        #1;
        checkOutput();
    endtask

    // One tick every third cycle, tick itself on the last of the three.
    task automatic tickEvery3(input logic e);
        applyStimulus(1'b0, e, 1'b1, 1'b0);
        applyStimulus(1'b0, e, 1'b1, 1'b0);
        applyStimulus(1'b1, e, 1'b1, 1'b0);
    endtask

    initial begin
        logic curWrap;
        logic seen;

        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2, 0, 0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1, 1};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2, 0, 0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 1, 1};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 1, 0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 1, 0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 0, 1, 0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 0};

        Reset   = 1'b0;
        tick    = 1'b0;
        enable  = 1'b0;
        mode    = ANIM_BOUNCE;
        restart = 1'b0;
        modelReset();
        repeat (2) @(posedge clock);
        #1;
        checkOutput();
        #3;
        Reset = 1'b1;

        // Bounce sequence, bounce-to-wrap switch at the top, hold, restart.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i].t, tbl[i].e, tbl[i].w, tbl[i].r);
            check($sformatf("tbl%0d_frame", i), int'(fa), tbl[i].f);
            check($sformatf("tbl%0d_dir", i),   int'(da), tbl[i].d);
            check($sformatf("tbl%0d_done", i),  int'(ca), tbl[i].c);
        end

        // Prescale by 4 with ticks every third cycle, plus a 2-tick enable gap.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) tickEvery3(1'b1);
        check("pre_before_step", int'(fb), 0);
        tickEvery3(1'b1);
        check("pre_first_step", int'(fb), 1);
        tickEvery3(1'b1);
        tickEvery3(1'b1);
        tickEvery3(1'b0);
        tickEvery3(1'b0);
        tickEvery3(1'b1);
        check("pre_gap_held", int'(fb), 1);
        tickEvery3(1'b1);
        check("pre_gap_step", int'(fb), 2);

        // Restart coincident with a tick at frame 2, prescaler 2.
        tickEvery3(1'b1);
        tickEvery3(1'b1);
        check("rst_pre_frame", int'(fb), 2);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        check("rst_frame", int'(fb), 0);
        check("rst_dir",   int'(db), 1);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        check("rst_fresh_hold", int'(fb), 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        check("rst_fresh_step", int'(fb), 1);

        // Bounded wait for the wrap-mode cycle pulse.
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
            if (cb) seen = 1'b1;
        end
        check("b_wrap_done_seen", int'(seen), 1);

        // Asynchronous reset between edges at frame 1.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        check("async_pre_frame", int'(fa), 1);
        #2;
        Reset = 1'b0;
        modelReset();
        #1;
        check("async_frame", int'(fa), 0);
        check("async_dir",   int'(da), 1);
        check("async_done",  int'(ca), 0);
        checkOutput();
        #2;
        Reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        check("async_restart_frame", int'(fa), 1);

        // Randomized traffic against the reference model.
        curWrap = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 15) == 0) curWrap = ~curWrap;
            applyStimulus(1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) != 0),
                          curWrap,
                          1'($urandom_range(0, 31) == 0));
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
